// File: rtl/twos_comp_decoder_pkg.sv
// Shared types and constants for the bit-serial two's-complement decoder.
package twos_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    DONE
  } state_t;

  localparam int DEF_WIDTH = 5;

  // Counter must hold WIDTH-1; a width of 1 covers the WIDTH=2 corner.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/twos_comp_decoder_serial_negate_cell.sv
// One LSB-first negation step: copy bits up to the first 1, then invert. Purely combinational.
module serial_negate_cell (
  input  logic b,
  input  logic negate,
  input  logic seen_one,
  output logic out_bit,
  output logic seen_one_next
);

  assign out_bit       = (negate && seen_one) ? ~b : b;
  assign seen_one_next = seen_one | b;

endmodule

// File: rtl/twos_comp_decoder.sv
// Signed-to-sign/magnitude converter, one bit per clock, result WIDTH cycles after accept, held until out_ready.
// Optional TWOS_DECODE_SAT_EN saturates the most negative input and flags it on overflow.
module twos_comp_decoder
  import twos_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] number,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] magnitude,
  output logic             is_negative,
  output logic             out_valid,
  input  logic             out_ready
`ifdef TWOS_DECODE_SAT_EN
  ,
  output logic             overflow
`endif
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             seen_one;
  logic             out_bit;
  logic             seen_one_next;
  logic [WIDTH-1:0] mag_next;

`ifdef TWOS_DECODE_SAT_EN
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  logic sat_flag;

  // Only meaningful while the result is presented.
  assign overflow = sat_flag & out_valid;
`endif

  serial_negate_cell u_cell (
    .b             (shreg[0]),
    .negate        (is_negative),
    .seen_one      (seen_one),
    .out_bit       (out_bit),
    .seen_one_next (seen_one_next)
  );

  assign mag_next = {out_bit, magnitude[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      shreg       <= '0;
      cnt         <= '0;
      seen_one    <= 1'b0;
      magnitude   <= '0;
      is_negative <= 1'b0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
`ifdef TWOS_DECODE_SAT_EN
      sat_flag    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            shreg       <= number;
            is_negative <= number[WIDTH-1];
            seen_one    <= 1'b0;
            cnt         <= CW'(WIDTH - 1);
            in_ready    <= 1'b0;
            state       <= CONVERT;
`ifdef TWOS_DECODE_SAT_EN
            sat_flag    <= 1'b0;
`endif
          end
        end
        CONVERT: begin
          shreg     <= shreg >> 1;
          seen_one  <= seen_one_next;
          magnitude <= mag_next;
          cnt       <= cnt - 1'b1;
          if (cnt == '0) begin
            state     <= DONE;
            out_valid <= 1'b1;
`ifdef TWOS_DECODE_SAT_EN
            // Only a negative operand can produce a magnitude of 2^(WIDTH-1).
            if (is_negative && mag_next == MOST_NEG) begin
              magnitude <= ~MOST_NEG;
              sat_flag  <= 1'b1;
            end
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
